// File: rtl/addsub_arb.sv
// Two-requester round-robin arbiter sharing one carry-lookahead add/sub unit.
// Define ADDSUB_ARB_STATS_EN to add saturating per-requester grant counters.
module addsub_arb #(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    input  logic             m0,
    input  logic             req1,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    input  logic             m1,
    output logic             ack0,
    output logic             ack1,
    output logic [W-1:0]     S,
    output logic             C,
    output logic             V,
    output logic             rsp_id,
    output logic             busy
`ifdef ADDSUB_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);

    if (W < 2 || CNT_W < 1) begin : g_param_check
        $error("addsub_arb: W must be >= 2 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic           op_m_q, op_m_d;
    logic           sel_q, sel_d;
    logic           last_q, last_d;
    logic [W-1:0]   s_q, s_d;
    logic           c_q, c_d;
    logic           v_q, v_d;
    logic           rsp_id_q, rsp_id_d;

    // Carry-lookahead add/sub on the latched operands
    logic [W-1:0]   b_eff;
    logic [W-1:0]   gen;
    logic [W-1:0]   prop;
    logic [W:0]     carry;
    logic [W-1:0]   sum;

    always_comb begin
        logic term;
        b_eff    = op_m_q ? ~op_b_q : op_b_q;
        gen      = op_a_q & b_eff;
        prop     = op_a_q ^ b_eff;
        carry    = '0;
        carry[0] = op_m_q;
        term     = 1'b0;
        // Each carry is a flat OR of generate terms, not a ripple chain
        for (int unsigned i = 0; i < W; i++) begin
            term = op_m_q;
            for (int unsigned k = 0; k <= i; k++) begin
                term = term & prop[k];
            end
            carry[i+1] = term;
            for (int unsigned j = 0; j <= i; j++) begin
                term = gen[j];
                for (int unsigned k = j + 1; k <= i; k++) begin
                    term = term & prop[k];
                end
                carry[i+1] = carry[i+1] | term;
            end
        end
        sum = prop ^ carry[W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_m_d   = op_m_q;
        sel_d    = sel_q;
        last_d   = last_q;
        s_d      = s_q;
        c_d      = c_q;
        v_d      = v_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    // On a tie, the requester not served last wins
                    sel_d   = (req0 && req1) ? ~last_q : req1;
                    op_a_d  = sel_d ? a1 : a0;
                    op_b_d  = sel_d ? b1 : b0;
                    op_m_d  = sel_d ? m1 : m0;
                    state_d = StExec;
                end
            end
            StExec: begin
                s_d      = sum;
                c_d      = carry[W];
                v_d      = carry[W] ^ carry[W-1];
                rsp_id_d = sel_q;
                state_d  = StResp;
            end
            StResp: begin
                last_d  = sel_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_m_q   <= 1'b0;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            s_q      <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            rsp_id_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_m_q   <= op_m_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            s_q      <= s_d;
            c_q      <= c_d;
            v_q      <= v_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    always_comb begin
        ack0   = (state_q == StResp) && !sel_q;
        ack1   = (state_q == StResp) && sel_q;
        busy   = (state_q != StIdle);
        S      = s_q;
        C      = c_q;
        V      = v_q;
        rsp_id = rsp_id_q;
    end

`ifdef ADDSUB_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (state_q == StResp) begin
            if (!sel_q && !(&cnt0_q)) begin
                cnt0_d = cnt0_q + 1'b1;
            end
            if (sel_q && !(&cnt1_q)) begin
                cnt1_d = cnt1_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_addsub_arb.sv
// Directed, table-driven bench for addsub_arb (W=4, CNT_W=2).
module tb_addsub_arb;

    localparam int W     = 4;
    localparam int CNT_W = 2;

    logic         clk;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         m0, m1;
    logic         ack0, ack1;
    logic [W-1:0] S;
    logic         C, V, rsp_id, busy;
`ifdef ADDSUB_ARB_STATS_EN
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
`endif

    int errors = 0;
    int checks = 0;

    addsub_arb #(.W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .a0       (a0),
        .b0       (b0),
        .m0       (m0),
        .req1     (req1),
        .a1       (a1),
        .b1       (b1),
        .m1       (m1),
        .ack0     (ack0),
        .ack1     (ack1),
        .S        (S),
        .C        (C),
        .V        (V),
        .rsp_id   (rsp_id),
        .busy     (busy)
`ifdef ADDSUB_ARB_STATS_EN
        ,
        .gnt_cnt0 (gnt_cnt0),
        .gnt_cnt1 (gnt_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack0 === 1'b1 && ack1 === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL both_acks: got ack0=1 ack1=1 expected at most one");
        end
    end

    task automatic drive(input logic id, input logic r, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic m);
        if (!id) begin
            req0 = r; a0 = a; b0 = b; m0 = m;
        end else begin
            req1 = r; a1 = a; b1 = b; m1 = m;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One operation: operands are scrambled once latched, which must not matter
    task automatic do_op(input vec_t v, input string name);
        int n;
        logic got;
        @(negedge clk);
        drive(v.id, 1'b1, v.a, v.b, v.m);
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (n == 1) drive(v.id, 1'b1, ~v.a, ~v.b, ~v.m);
            if (ack0 || ack1) got = 1'b1;
        end
        chk({name, "_latency"}, n, 2);
        chk({name, "_ack0"}, ack0, !v.id);
        chk({name, "_ack1"}, ack1, v.id);
        chk({name, "_S"}, S, v.s);
        chk({name, "_C"}, C, v.c);
        chk({name, "_V"}, V, v.v);
        chk({name, "_rsp_id"}, rsp_id, v.id);
        drive(v.id, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        int   cyc, n_acks, last_cyc, n;
        logic re0, re1, got;
        logic exp_id;

        vecs[0] = '{1'b0, 4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 4'b0000, 4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 4'b0110, 4'b0101, 1'b0, 4'b1011, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0000, 1'b1, 1'b0};

        rst = 1'b1;
        req0 = 1'b0; a0 = '0; b0 = '0; m0 = 1'b0;
        req1 = 1'b0; a1 = '0; b1 = '0; m1 = 1'b0;
        do_reset();

        // Reset state, then idle for 10 cycles
        chk("rst_S", S, 0);
        chk("rst_C", C, 0);
        chk("rst_V", V, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle_busy%0d", i), busy, 0);
        end

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Contention: both held from the same cycle, re-raised after each ack
        do_reset();
        @(negedge clk);
        a0 = 4'd1; b0 = 4'd2; m0 = 1'b0;
        a1 = 4'd5; b1 = 4'd1; m1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        cyc = 0; n_acks = 0; last_cyc = 0; re0 = 1'b0; re1 = 1'b0;
        while (n_acks < 4 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (re0) begin req0 = 1'b1; re0 = 1'b0; end
            if (re1) begin req1 = 1'b1; re1 = 1'b0; end
            if (ack0 || ack1) begin
                exp_id = n_acks[0];
                chk($sformatf("cont%0d_id", n_acks), ack1, exp_id);
                chk($sformatf("cont%0d_gap", n_acks), cyc - last_cyc,
                    (n_acks == 0) ? 2 : 3);
                chk($sformatf("cont%0d_S", n_acks), S, exp_id ? 4'd4 : 4'd3);
                chk($sformatf("cont%0d_C", n_acks), C, exp_id);
                last_cyc = cyc;
                n_acks++;
                if (ack0) begin req0 = 1'b0; re0 = 1'b1; end
                if (ack1) begin req1 = 1'b0; re1 = 1'b1; end
            end
        end
        chk("cont_count", n_acks, 4);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset during EXEC drops the operation; held req is served afresh
        @(negedge clk);
        drive(1'b0, 1'b1, 4'b1001, 4'b0011, 1'b0);
        @(negedge clk);
        chk("midrst_busy_exec", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_ack0", ack0, 0);
        chk("midrst_S", S, 0);
        chk("midrst_C", C, 0);
        chk("midrst_V", V, 0);
        rst = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (ack0 || ack1) got = 1'b1;
        end
        chk("midrst_latency", n, 2);
        chk("midrst_ack0_after", ack0, 1);
        chk("midrst_S_after", S, 4'b1100);
        chk("midrst_V_after", V, 0);
        req0 = 1'b0;

`ifdef ADDSUB_ARB_STATS_EN
        do_reset();
        chk("stats_rst0", gnt_cnt0, 0);
        chk("stats_rst1", gnt_cnt1, 0);
        for (int i = 0; i < 5; i++) begin
            do_op(vecs[0], $sformatf("stats_op%0d", i));
            if (i == 1) chk("stats_cnt0_two", gnt_cnt0, 1);
        end
        @(negedge clk);
        chk("stats_cnt0_sat", gnt_cnt0, 3);
        chk("stats_cnt1", gnt_cnt1, 0);
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
